// File: rtl/xbar_arbiter_pkg.sv
// Shared types and sizing for the crossbar arbiter slice.
// The requester set is NUM_CPUS CPUs plus one memory controller at the top index.
package xbar_arbiter_pkg;

    localparam int unsigned NUM_CPUS  = 4;
    localparam int unsigned NUM_REQ   = NUM_CPUS + 1;
    localparam int unsigned XBAR_ID_W = $clog2(NUM_CPUS + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    typedef logic [NUM_REQ-1:0]   req_vec_t;
    typedef logic [XBAR_ID_W-1:0] req_id_t;

    function automatic req_id_t onehot_to_id(input req_vec_t v);
        req_id_t id;
        id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (v[i]) id = req_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/xbar_arbiter_rr_pick.sv
// Combinational rotate-priority picker: one-hot of the first request at or after ptr_i.
module rr_pick
    import xbar_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [XBAR_ID_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_o
);

    int unsigned idx_sum;
    req_id_t     idx;
    logic        found;

    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        idx_sum = 0;
        idx     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_sum = 32'(ptr_i) + off;
            if (idx_sum >= NUM_REQ) idx_sum = idx_sum - NUM_REQ;
            idx = req_id_t'(idx_sum);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_arbiter.sv
// Crossbar grant arbiter: round-robin IDLE/HOLD FSM with forced revocation after MAX_HOLD cycles.
// Define XBAR_ARB_MEM_PRIORITY_EN to let the memory controller win every IDLE arbitration.
module xbar_arbiter
    import xbar_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   rel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [XBAR_ID_W-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
    localparam req_id_t    MEM_ID     = req_id_t'(NUM_CPUS);
    localparam req_vec_t   MEM_ONEHOT = req_vec_t'(1) << NUM_CPUS;

    arb_state_e state_q, state_d;
    req_vec_t   gnt_q, gnt_d, pick;
    req_id_t    id_q, id_d, ptr_q, ptr_d, pick_id, ptr_after_pick;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d, timeout_q, timeout_d;
    logic       holder_done, expired;

    rr_pick u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    assign pick_id        = onehot_to_id(pick);
    assign ptr_after_pick = (pick_id == MEM_ID) ? '0 : pick_id + 1'b1;
    // Dropping req without rel counts as a release by the holder.
    assign holder_done    = |(gnt_q & (rel | ~req));
    assign expired        = (cnt_q == HOLD_LAST);
    assign busy_d         = (state_d == ST_HOLD);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    state_d = ST_HOLD;
`ifdef XBAR_ARB_MEM_PRIORITY_EN
                    if (req[NUM_CPUS]) begin
                        gnt_d = MEM_ONEHOT;
                        id_d  = MEM_ID;
                    end else begin
                        gnt_d = pick;
                        id_d  = pick_id;
                        ptr_d = ptr_after_pick;
                    end
`else
                    gnt_d = pick;
                    id_d  = pick_id;
                    ptr_d = ptr_after_pick;
`endif
                end
            end
            ST_HOLD: begin
                if (holder_done || expired) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    id_d      = '0;
                    cnt_d     = '0;
                    timeout_d = !holder_done;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_via_idle: assert property (@(posedge clk) disable iff (rst)
        !$stable(gnt_q) |-> ($past(state_q) == ST_IDLE || gnt_q == '0));
    a_timeout_at_limit: assert property (@(posedge clk) disable iff (rst)
        timeout_q |-> ($past(cnt_q) == HOLD_LAST));

endmodule

// File: tb/tb_xbar_arbiter.sv
// Bench for xbar_arbiter: per-cycle compare against a grant-level model, directed scenarios, random traffic.
// Honours XBAR_ARB_MEM_PRIORITY_EN the same way the design does.
module tb_xbar_arbiter;
    import xbar_arbiter_pkg::*;

    localparam int MAXH = 4;
    localparam int NREQ = NUM_CPUS + 1;

    logic                 clk, rst;
    logic [NREQ-1:0]      req, rel, gnt;
    logic [XBAR_ID_W-1:0] gnt_id;
    logic                 busy, timeout;

    int checks = 0;
    int errors = 0;

    xbar_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        return ((v >> i) & 1) != 0;
    endfunction

    function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
        for (int o = 0; o < NREQ; o++) begin
            if (bit_of(r, (p + o) % NREQ)) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    // Model: who holds the grant, how many cycles it has been visible, next round-robin start.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_held   = 0;
    bit m_to     = 1'b0;
    bit m_valid  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_holder = -1;
            m_ptr    = 0;
            m_held   = 0;
            m_to     = 1'b0;
            m_valid  = 1'b1;
        end else if (m_holder < 0) begin
            m_to = 1'b0;
            if (req != '0) begin
`ifdef XBAR_ARB_MEM_PRIORITY_EN
                if (req[NUM_CPUS]) begin
                    m_holder = NUM_CPUS;
                end else begin
                    m_holder = rr_first(req, m_ptr);
                    m_ptr    = (m_holder + 1) % NREQ;
                end
`else
                m_holder = rr_first(req, m_ptr);
                m_ptr    = (m_holder + 1) % NREQ;
`endif
                m_held = 1;
            end
        end else if (bit_of(rel, m_holder) || !bit_of(req, m_holder)) begin
            m_holder = -1;
            m_to     = 1'b0;
        end else if (m_held >= MAXH) begin
            m_holder = -1;
            m_to     = 1'b1;
        end else begin
            m_held++;
            m_to = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt", int'(gnt), (m_holder < 0) ? 0 : (1 << m_holder));
            check("gnt_id", int'(gnt_id), (m_holder < 0) ? 0 : m_holder);
            check("busy", int'(busy), int'(m_holder >= 0));
            check("timeout", int'(timeout), int'(m_to));
            check("gnt_onehot0", int'($onehot0(gnt)), 1);
        end
    end

    initial begin
        int order[$];
        int exp_order[6];
        int n;
        exp_order = '{0, 1, 2, 3, 4, 0};

        rst = 1'b1; req = '0; rel = '0;
        repeat (3) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_gnt_id", int'(gnt_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout), 0);
        rst = 1'b0;

        // Single requester, released by rel on cycle 3.
        req = 5'b00100;
        tick();
        check("single_gnt", int'(gnt), 5'b00100);
        check("single_gnt_id", int'(gnt_id), 2);
        check("single_busy", int'(busy), 1);
        tick(); tick();
        rel = 5'b00100;
        tick();
        rel = '0; req = '0;
        check("single_release", int'(gnt), 0);

        // Reset while index 3 holds.
        req = 5'b01000;
        tick();
        check("midhold_gnt", int'(gnt), 5'b01000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midhold_rst_gnt", int'(gnt), 0);
        check("midhold_rst_busy", int'(busy), 0);
        check("midhold_rst_timeout", int'(timeout), 0);
        req = 5'b11111;
        tick();
        check("after_rst_gnt", int'(gnt), 5'b00001);
        rel = 5'b00001; req = '0;
        tick();
        rel = '0;

        // All requesting, each grant released after 2 cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (gnt == '0 && n < 10) begin
                tick();
                n++;
            end
            check("rr_grant_seen", int'(gnt != '0), 1);
            order.push_back(int'(gnt_id));
            tick();
            rel = gnt;
            tick();
            rel = '0;
        end
        req = '0;
        for (int g = 0; g < 6; g++) check("rr_order", order[g], exp_order[g]);

        // Hold without release until MAX_HOLD expiry.
        tick();
        req = 5'b00010;
        tick();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!gnt[1]) break;
            n++;
            tick();
        end
        check("to_hold_len", n, 4);
        check("to_pulse", int'(timeout), 1);
        check("to_gnt", int'(gnt), 0);
        req = '0;
        tick();
        check("to_pulse_end", int'(timeout), 0);

        // Release on the expiry cycle.
        req = 5'b00010;
        tick();
        check("simul_gnt", int'(gnt), 5'b00010);
        repeat (3) tick();
        rel = 5'b00010;
        tick();
        rel = '0; req = '0;
        check("simul_gnt_clear", int'(gnt), 0);
        check("simul_no_timeout", int'(timeout), 0);

        // ptr=1 with CPU 1 and memory both requesting.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 5'b00001;
        tick();
        rel = 5'b00001; req = '0;
        tick();
        rel = '0;
        req = 5'b10010;
        tick();
`ifdef XBAR_ARB_MEM_PRIORITY_EN
        check("prio_mem_gnt", int'(gnt), 5'b10000);
        rel = 5'b10000; req = 5'b00010;
        tick();
        rel = '0;
        tick();
        check("prio_next_gnt", int'(gnt), 5'b00010);
        check("prio_next_id", int'(gnt_id), 1);
`else
        check("rr_cpu_gnt", int'(gnt), 5'b00010);
        rel = 5'b00010; req = 5'b10000;
        tick();
        rel = '0;
        tick();
        check("rr_mem_next_gnt", int'(gnt), 5'b10000);
        check("rr_mem_next_id", int'(gnt_id), 4);
`endif
        rel = gnt; req = '0;
        tick();
        rel = '0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            rel = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; req = '0; rel = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
